// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder memory model.
// Holds the FSM state encoding, beat indexing constants and the
// byte-mask width derivation used by the responder and its array.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        READ_BURST = 2'd2,
        WRITE_DATA = 2'd3
    } state_e;

    localparam int unsigned BEAT_IDX_BITS = 2;
    localparam int unsigned MEM_BEATS     = 4;
    localparam int unsigned BYTE_BITS     = 8;

    // One enable bit per byte lane of a data beat.
    function automatic int unsigned mask_bits(input int unsigned data_bits);
        return data_bits / BYTE_BITS;
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Beat-addressed storage for mem_responder.
// 2^DEPTH_BITS x DATA_BITS array with per-byte write enables and a
// registered read port whose output is zero whenever no read was issued.
// Ports:
//   clk, reset          clock, synchronous active-high reset (read register only)
//   wr_en/addr/data/mask byte-masked write port
//   rd_en/addr          read request; rd_data valid the following cycle
//   rd_data             registered read data
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter  int unsigned DATA_BITS  = 128,
    parameter  int unsigned DEPTH_BITS = 10,
    localparam int unsigned MASK_BITS  = mask_bits(DATA_BITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic [MASK_BITS-1:0]  wr_mask,
    input  logic                  rd_en,
    input  logic [DEPTH_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0]  rd_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] rd_data_d;
    logic [DATA_BITS-1:0] rd_data_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < MASK_BITS; i++) begin
                if (wr_mask[i]) begin
                    mem_q[wr_addr][i*BYTE_BITS +: BYTE_BITS] <= wr_data[i*BYTE_BITS +: BYTE_BITS];
                end
            end
        end
    end

    // Zero when idle so the output is clean outside read bursts.
    always_comb begin
        rd_data_d = '0;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the cache-to-DRAM request interface.
// Accepts one line request at a time: reads return MEM_BEATS beats after
// LATENCY idle cycles, writes absorb MEM_BEATS byte-masked beats.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mem_req_valid/ready/addr/rw     line request handshake
//   mem_req_data_valid/ready/bits/mask  write beat handshake
//   mem_resp_valid/data             read beats, no backpressure
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter  int unsigned ADDR_BITS  = 28,
    parameter  int unsigned DATA_BITS  = 128,
    parameter  int unsigned DEPTH_BITS = 10,
    parameter  int unsigned LATENCY    = 8,
    parameter  int unsigned BEATS      = 4,
    localparam int unsigned MASK_BITS  = mask_bits(DATA_BITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_req_valid,
    output logic                 mem_req_ready,
    input  logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic                 mem_req_rw,
    input  logic                 mem_req_data_valid,
    output logic                 mem_req_data_ready,
    input  logic [DATA_BITS-1:0] mem_req_data_bits,
    input  logic [MASK_BITS-1:0] mem_req_data_mask,
    output logic                 mem_resp_valid,
    output logic [DATA_BITS-1:0] mem_resp_data
);

    localparam int unsigned LINE_BITS = DEPTH_BITS - BEAT_IDX_BITS;
    localparam int unsigned WAIT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [BEAT_IDX_BITS-1:0] LAST_BEAT = BEAT_IDX_BITS'(MEM_BEATS - 1);

    state_e                   state_q, state_d;
    logic [BEAT_IDX_BITS-1:0] beat_q, beat_d;
    logic [WAIT_BITS-1:0]     wait_q, wait_d;
    logic [LINE_BITS-1:0]     line_q, line_d;
    logic                     ready_q, ready_d;
    logic                     data_ready_q, data_ready_d;
    logic                     resp_valid_q, resp_valid_d;

    logic                     req_fire;
    logic                     data_fire;
    logic [BEAT_IDX_BITS-1:0] rd_beat;
    logic                     rd_en;
    logic                     wr_en;

    // Address bits above the array depth alias; the in-line beat bits are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_req_addr[ADDR_BITS-1:DEPTH_BITS], mem_req_addr[BEAT_IDX_BITS-1:0]};
    logic unused_beats;
    assign unused_beats = ^(BEATS[0]);

    assign req_fire  = mem_req_valid & ready_q;
    assign data_fire = mem_req_data_valid & data_ready_q;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            wait_q       <= '0;
            line_q       <= '0;
            ready_q      <= 1'b0;
            data_ready_q <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            line_q       <= line_d;
            ready_q      <= ready_d;
            data_ready_q <= data_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    line_d = mem_req_addr[DEPTH_BITS-1:BEAT_IDX_BITS];
                    beat_d = '0;
                    if (mem_req_rw) begin
                        state_d = WRITE_DATA;
                    end else if (LATENCY == 0) begin
                        state_d = READ_BURST;
                    end else begin
                        state_d = READ_WAIT;
                        wait_d  = WAIT_BITS'(LATENCY - 1);
                    end
                end
            end
            READ_WAIT: begin
                if (wait_q == '0) begin
                    state_d = READ_BURST;
                end else begin
                    wait_d = wait_q - WAIT_BITS'(1);
                end
            end
            READ_BURST: begin
                beat_d = beat_q + BEAT_IDX_BITS'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end
            end
            WRITE_DATA: begin
                if (data_fire) begin
                    beat_d = beat_q + BEAT_IDX_BITS'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered handshake outputs follow the state being entered.
    always_comb begin
        ready_d      = 1'b0;
        data_ready_d = 1'b0;
        resp_valid_d = 1'b0;
        unique case (state_d)
            IDLE:       ready_d      = 1'b1;
            WRITE_DATA: data_ready_d = 1'b1;
            READ_BURST: resp_valid_d = 1'b1;
            default:    ready_d      = 1'b0;
        endcase
    end

    // Reads are issued one cycle ahead of the beat they produce; beat_q
    // tracks the beat on the output, so the next read is beat_q+1.
    assign rd_beat = (state_q == READ_BURST) ? beat_q + BEAT_IDX_BITS'(1) : '0;
    assign rd_en   = (state_d == READ_BURST) & ~reset;
    assign wr_en   = data_fire & ~reset;

    mem_resp_array #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr ({line_q, beat_q}),
        .wr_data (mem_req_data_bits),
        .wr_mask (mem_req_data_mask),
        .rd_en   (rd_en),
        .rd_addr ({line_d, rd_beat}),
        .rd_data (mem_resp_data)
    );

    assign mem_req_ready      = ready_q;
    assign mem_req_data_ready = data_ready_q;
    assign mem_resp_valid     = resp_valid_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=8, one at
// LATENCY=0. Expected read beats come from a byte-level reference model
// and flow through a scoreboard queue.
module tb_mem_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_valid0 = 1'b0;
    logic [27:0]  req_addr = '0;
    logic         req_rw = 1'b0;
    logic         data_valid = 1'b0;
    logic [127:0] data_bits = '0;
    logic [15:0]  data_mask = '0;

    logic         ready, data_ready, resp_valid;
    logic [127:0] resp_data;
    logic         ready0, data_ready0, resp_valid0;
    logic [127:0] resp_data0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [127:0] model [2][1024];
    logic [127:0] sb [$];

    mem_responder #(.LATENCY(8)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(req_valid), .mem_req_ready(ready),
        .mem_req_addr(req_addr), .mem_req_rw(req_rw),
        .mem_req_data_valid(data_valid), .mem_req_data_ready(data_ready),
        .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
        .mem_resp_valid(resp_valid), .mem_resp_data(resp_data)
    );

    mem_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .mem_req_valid(req_valid0), .mem_req_ready(ready0),
        .mem_req_addr(req_addr), .mem_req_rw(req_rw),
        .mem_req_data_valid(data_valid), .mem_req_data_ready(data_ready0),
        .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
        .mem_resp_valid(resp_valid0), .mem_resp_data(resp_data0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic o_ready(input bit sel);
        return sel ? ready0 : ready;
    endfunction
    function automatic logic o_dready(input bit sel);
        return sel ? data_ready0 : data_ready;
    endfunction
    function automatic logic o_valid(input bit sel);
        return sel ? resp_valid0 : resp_valid;
    endfunction
    function automatic logic [127:0] o_data(input bit sel);
        return sel ? resp_data0 : resp_data;
    endfunction

    task automatic set_req(input bit sel, input logic v);
        if (sel) req_valid0 = v;
        else     req_valid  = v;
    endtask

    task automatic wait_ready(input bit sel, output int t);
        int n = 0;
        while (!o_ready(sel) && n < 200) begin
            step();
            n++;
        end
        chk("req_ready_wait", o_ready(sel), 1'b1);
        t = cyc;
    endtask

    // vpat bit i gives data_valid for the i-th cycle of the write phase.
    task automatic write_line(input bit sel, input logic [27:0] addr,
                              input logic [127:0] d [4], input logic [15:0] m [4],
                              input logic [31:0] vpat, input int stop_after);
        int t;
        int fired = 0;
        int n = 0;
        logic dv;
        logic [9:0] wi;
        req_addr = addr;
        req_rw   = 1'b1;
        set_req(sel, 1'b1);
        wait_ready(sel, t);
        step();
        set_req(sel, 1'b0);
        req_rw   = 1'b0;
        req_addr = 28'h0FFFFFC;
        while (fired < stop_after && n < 64) begin
            dv = (n < 32) ? vpat[n] : 1'b1;
            data_valid = dv;
            data_bits  = d[fired];
            data_mask  = m[fired];
            chk("wr_data_ready", o_dready(sel), 1'b1);
            chk("wr_req_ready_low", o_ready(sel), 1'b0);
            step();
            if (dv) begin
                wi = {addr[9:2], 2'(fired)};
                for (int b = 0; b < 16; b++) begin
                    if (m[fired][b]) model[sel][wi][b*8 +: 8] = d[fired][b*8 +: 8];
                end
                fired++;
            end
            n++;
        end
        data_valid = 1'b0;
        if (stop_after == 4) begin
            chk("wr_done_ready", o_ready(sel), 1'b1);
            chk("wr_done_dready", o_dready(sel), 1'b0);
        end
    endtask

    // abort_beat < 4 asserts reset during that beat.
    task automatic read_line(input bit sel, input logic [27:0] addr, input int lat,
                             input int abort_beat, output int t_fire);
        logic [127:0] e;
        req_addr = addr;
        req_rw   = 1'b0;
        set_req(sel, 1'b1);
        wait_ready(sel, t_fire);
        for (int k = 0; k < 4; k++) sb.push_back(model[sel][{addr[9:2], 2'(k)}]);
        step();
        set_req(sel, 1'b0);
        req_rw   = 1'b1;
        req_addr = 28'h0FFFFFC;
        for (int c = 1; c <= lat + 4; c++) begin
            if (c >= lat + 1) begin
                e = sb.pop_front();
                chk("rd_valid", o_valid(sel), 1'b1);
                chk("rd_beat_data", o_data(sel), e);
                if (c - lat - 1 == abort_beat) begin
                    reset = 1'b1;
                    step();
                    chk("abort_valid", o_valid(sel), 1'b0);
                    chk("abort_data", o_data(sel), '0);
                    step();
                    reset = 1'b0;
                    sb.delete();
                    return;
                end
            end else begin
                chk("rd_wait_valid", o_valid(sel), 1'b0);
                chk("rd_wait_data", o_data(sel), '0);
            end
            chk("rd_req_ready_low", o_ready(sel), 1'b0);
            step();
        end
        chk("rd_done_ready", o_ready(sel), 1'b1);
        chk("rd_done_valid", o_valid(sel), 1'b0);
    endtask

    initial begin
        logic [127:0] d [4];
        logic [15:0]  m [4];
        int t1, t2;

        // 1. Reset, then full-mask write and read back.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", ready, 1'b0);
            chk("rst_dready", data_ready, 1'b0);
            chk("rst_valid", resp_valid, 1'b0);
            chk("rst_data", resp_data, '0);
        end
        reset = 1'b0;
        chk("post_rst_ready", ready, 1'b0);
        chk("post_rst_valid", resp_valid, 1'b0);
        step();
        chk("idle_ready", ready, 1'b1);

        for (int k = 0; k < 4; k++) begin
            d[k] = 128'(k + 1);
            m[k] = 16'hFFFF;
        end
        write_line(0, 28'h0000010, d, m, 32'hFFFF_FFFF, 4);
        read_line(0, 28'h0000010, 8, 4, t1);

        // 2. Partial mask over an 0xAA-filled line.
        for (int k = 0; k < 4; k++) d[k] = {16{8'hAA}};
        write_line(0, 28'h0000010, d, m, 32'hFFFF_FFFF, 4);
        for (int k = 0; k < 4; k++) begin
            d[k] = {16{8'h55}};
            m[k] = 16'h0000;
        end
        m[0] = 16'h000F;
        write_line(0, 28'h0000010, d, m, 32'hFFFF_FFFF, 4);
        chk("model_partial", model[0][10'h010], {{12{8'hAA}}, {4{8'h55}}});
        read_line(0, 28'h0000010, 8, 4, t1);

        // 3. Early data is refused; bubbles stall the write.
        data_valid = 1'b1;
        data_bits  = {8{16'hDEAD}};
        data_mask  = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            chk("early_dready", data_ready, 1'b0);
            step();
        end
        data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d[k] = {4{32'hC0DE_0000 + 32'(k)}};
            m[k] = 16'hFFFF;
        end
        write_line(0, 28'h0000020, d, m, 32'h0000_0059, 4);
        read_line(0, 28'h0000020, 8, 4, t1);

        // 4. Low address bits ignored; upper bits alias.
        read_line(0, 28'h0000013, 8, 4, t1);
        read_line(0, 28'h0000410, 8, 4, t1);

        // 5. Zero latency, back-to-back reads.
        for (int k = 0; k < 4; k++) begin
            d[k] = {16{8'(8'h30 + k)}};
            m[k] = 16'hFFFF;
        end
        write_line(1, 28'h0000030, d, m, 32'hFFFF_FFFF, 4);
        for (int k = 0; k < 4; k++) d[k] = {16{8'(8'h40 + k)}};
        write_line(1, 28'h0000040, d, m, 32'hFFFF_FFFF, 4);
        read_line(1, 28'h0000030, 0, 4, t1);
        read_line(1, 28'h0000040, 0, 4, t2);
        chk("b2b_fire_gap", 128'(t2 - t1), 128'd5);

        // 6. Reset during a read burst, then during a write.
        read_line(0, 28'h0000010, 8, 1, t1);
        chk("abort_rd_ready0", ready, 1'b0);
        step();
        chk("abort_rd_ready1", ready, 1'b1);

        for (int k = 0; k < 4; k++) d[k] = {4{32'hBEEF_0000 + 32'(k)}};
        write_line(0, 28'h0000020, d, m, 32'hFFFF_FFFF, 2);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("abort_wr_ready0", ready, 1'b0);
        step();
        chk("abort_wr_ready1", ready, 1'b1);
        chk("abort_wr_dready", data_ready, 1'b0);
        read_line(0, 28'h0000020, 8, 4, t1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
